// File: rtl/product_bcd_converter.sv
// Signed A:B product to sign-magnitude BCD converter.
// Serial double dabble: one product bit per clock.
module product_bcd_converter #(
  parameter int IN_W   = 16,
  parameter int DIGITS = 5
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [IN_W/2-1:0]     Aval,
  input  logic [IN_W/2-1:0]     Bval,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Neg,
  output logic [4*DIGITS-1:0]   Bcd
);

  localparam int CW = $clog2(IN_W + 1);
  localparam int SW = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [IN_W-1:0]      r_mag;
  logic [SW-1:0]        r_scr;
  logic [CW-1:0]        r_cnt;
  logic                 r_neg;
  logic [SW-1:0]        r_bcd;
  logic                 r_neg_o;
  logic [IN_W-1:0]      w_v;
  logic [IN_W-1:0]      w_abs;
  logic [SW-1:0]        w_adj;
  logic [SW+IN_W-1:0]   w_sh;
  logic                 w_last;

  assign w_v    = {Aval, Bval};
  // 0x8000 negates to itself, which reads as 32768 unsigned
  assign w_abs  = w_v[IN_W-1] ? (~w_v) + IN_W'(1) : w_v;
  assign w_last = (r_cnt == CW'(1));

  always_comb begin
    w_adj = r_scr;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_scr[4*d +: 4] >= 4'd5)
        w_adj[4*d +: 4] = r_scr[4*d +: 4] + 4'd3;
    end
    w_sh = {w_adj, r_mag} << 1;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (Start)  w_next = S_SHIFT;
      S_SHIFT: if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_mag   <= '0;
      r_scr   <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_bcd   <= '0;
      r_neg_o <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && Start) begin
        r_neg <= w_v[IN_W-1];
        r_mag <= w_abs;
        r_scr <= '0;
        r_cnt <= CW'(IN_W);
      end else if (r_state == S_SHIFT) begin
        r_scr <= w_sh[SW+IN_W-1 -: SW];
        r_mag <= w_sh[IN_W-1:0];
        r_cnt <= r_cnt - CW'(1);
        if (w_last) begin
          r_bcd   <= w_sh[SW+IN_W-1 -: SW];
          r_neg_o <= r_neg;
        end
      end
    end
  end

  assign Busy = (r_state != S_IDLE);
  assign Done = (r_state == S_DONE);
  assign Neg  = r_neg_o;
  assign Bcd  = r_bcd;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Bench for product_bcd_converter.
// Random and directed conversions against an arithmetic model.
module tb_product_bcd_converter;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [7:0]  Aval;
  logic [7:0]  Bval;
  logic        Busy;
  logic        Done;
  logic        Neg;
  logic [19:0] Bcd;

  int checks = 0;
  int errors = 0;
  logic [20:0] last_exp = '0;

  product_bcd_converter #(.IN_W(16), .DIGITS(5)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .Aval(Aval), .Bval(Bval),
    .Busy(Busy), .Done(Done), .Neg(Neg), .Bcd(Bcd)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Returns {neg, bcd} from plain decimal arithmetic
  function automatic logic [20:0] model(input logic [7:0] a,
                                        input logic [7:0] b);
    int v, m;
    logic [19:0] r;
    logic n;
    v = int'({a, b});
    n = v >= 32768;
    m = n ? 65536 - v : v;
    r = '0;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return {n, r};
  endfunction

  task automatic run_conv(input logic [7:0] a, input logic [7:0] b,
                          output int busyc, output int donec,
                          output int didx, output logic [20:0] res);
    busyc = 0; donec = 0; didx = -1; res = '0;
    @(negedge Clk);
    Aval = a; Bval = b; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    if (Busy) busyc++;
    for (int i = 1; i <= 24; i++) begin
      @(posedge Clk); #1;
      if (Busy) busyc++;
      if (Done) begin
        donec++; didx = i; res = {Neg, Bcd};
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0; Start = 1'b0; Aval = '0; Bval = '0;
    #3;
    checks++;
    if ({Busy, Done, Neg, Bcd} !== 23'd0) begin
      errors++;
      $display("FAIL reset_async got %h want 0", {Busy, Done, Neg, Bcd});
    end
    @(negedge Clk); Reset = 1'b1;
    repeat (5) @(negedge Clk);
    checks++;
    if ({Busy, Done, Neg, Bcd} !== 23'd0) begin
      errors++;
      $display("FAIL reset_idle got %h want 0", {Busy, Done, Neg, Bcd});
    end
  endtask

  task automatic test_directed(input logic [7:0] a, input logic [7:0] b,
                               input logic [20:0] want, input bit timing);
    int bc, dc, di;
    logic [20:0] r;
    run_conv(a, b, bc, dc, di, r);
    checks++;
    if (dc !== 1) begin
      errors++;
      $display("FAIL done_count %h%h got %0d want 1", a, b, dc);
    end
    checks++;
    if (r !== want) begin
      errors++;
      $display("FAIL result %h%h got %h want %h", a, b, r, want);
    end
    if (timing) begin
      checks++;
      if (di !== 16) begin
        errors++;
        $display("FAIL latency got %0d want 16", di);
      end
      checks++;
      if (bc !== 17) begin
        errors++;
        $display("FAIL busy_cycles got %0d want 17", bc);
      end
    end
    last_exp = want;
  endtask

  task automatic test_positive();
    test_directed(8'h01, 8'h9D, {1'b0, 20'h00413}, 1'b1);
  endtask

  task automatic test_negative();
    test_directed(8'hFE, 8'h63, {1'b1, 20'h00413}, 1'b0);
    test_directed(8'hFF, 8'hE0, {1'b1, 20'h00032}, 1'b0);
  endtask

  task automatic test_extremes();
    test_directed(8'h80, 8'h00, {1'b1, 20'h32768}, 1'b1);
    test_directed(8'h7F, 8'hFF, {1'b0, 20'h32767}, 1'b0);
    test_directed(8'h00, 8'h00, {1'b0, 20'h00000}, 1'b0);
  endtask

  task automatic test_random();
    int bc, dc, di;
    logic [20:0] r, e;
    logic [7:0] a, b;
    for (int n = 0; n < 20; n++) begin
      a = 8'($urandom); b = 8'($urandom);
      e = model(a, b);
      run_conv(a, b, bc, dc, di, r);
      checks++;
      if (dc !== 1 || di !== 16 || r !== e) begin
        errors++;
        $display("FAIL random %h%h got %h done %0d at %0d want %h",
                 a, b, r, dc, di, e);
      end
      last_exp = e;
    end
  endtask

  task automatic test_handshake();
    int dc = 0;
    int hold_bad = 0;
    logic [20:0] r = '0;
    @(negedge Clk);
    Aval = 8'h01; Bval = 8'h9D; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      @(posedge Clk); #1;
      if (i == 5) begin
        Start = 1'b1; Aval = 8'hFE; Bval = 8'h63;
      end
      if (i == 6) Start = 1'b0;
      if (i < 16 && {Neg, Bcd} !== last_exp) hold_bad++;
      if (Done) begin
        dc++; r = {Neg, Bcd};
      end
    end
    checks++;
    if (hold_bad != 0) begin
      errors++;
      $display("FAIL hold_prior got %0d changes want 0", hold_bad);
    end
    checks++;
    if (dc !== 1 || r !== {1'b0, 20'h00413}) begin
      errors++;
      $display("FAIL ignore_start got %h x%0d want 000413 x1", r, dc);
    end
    last_exp = {1'b0, 20'h00413};
  endtask

  task automatic test_back_to_back();
    int times[$];
    int bad = 0;
    logic [7:0] a, b;
    logic [20:0] e;
    a = 8'($urandom_range(1, 255)); b = 8'($urandom);
    e = model(a, b);
    @(negedge Clk);
    Aval = a; Bval = b; Start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (Done) begin
        times.push_back(i);
        if ({Neg, Bcd} !== e) bad++;
      end
    end
    Start = 1'b0;
    repeat (20) @(negedge Clk);
    checks++;
    if (times.size() < 5) begin
      errors++;
      $display("FAIL held_start_count got %0d want >=5", times.size());
    end
    for (int k = 1; k < times.size(); k++)
      if (times[k] - times[k-1] != 18) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL held_start_period got %0d bad want 0", bad);
    end
    last_exp = e;
  endtask

  task automatic test_reset_midop();
    int dc = 0;
    int bc, di;
    logic [20:0] r, e;
    logic [7:0] a, b;
    @(negedge Clk);
    Aval = 8'h80; Bval = 8'h00; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (8) @(posedge Clk);
    #3;
    checks++;
    if (Busy !== 1'b1 || {Neg, Bcd} !== last_exp) begin
      errors++;
      $display("FAIL pre_reset busy %b got %h want 1 %h",
               Busy, {Neg, Bcd}, last_exp);
    end
    Reset = 1'b0;
    #1;
    checks++;
    if ({Busy, Done, Neg, Bcd} !== 23'd0) begin
      errors++;
      $display("FAIL reset_midop got %h want 0", {Busy, Done, Neg, Bcd});
    end
    @(negedge Clk); Reset = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge Clk);
      if (Done || Busy) dc++;
    end
    checks++;
    if (dc != 0) begin
      errors++;
      $display("FAIL no_done_after_reset got %0d want 0", dc);
    end
    a = 8'($urandom); b = 8'($urandom);
    e = model(a, b);
    run_conv(a, b, bc, dc, di, r);
    checks++;
    if (dc !== 1 || r !== e) begin
      errors++;
      $display("FAIL post_reset %h%h got %h x%0d want %h", a, b, r, dc, e);
    end
  endtask

  initial begin
    test_reset();
    test_positive();
    test_negative();
    test_extremes();
    test_random();
    test_handshake();
    test_back_to_back();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
